// File: rtl/mem_req_queue_pkg.sv
// Shared types and defaults for the memory request queue.
// FSM encoding and request-entry width helper.
package mem_pkg;

  localparam int MEM_DEPTH  = 4;
  localparam int MEM_ADDR_W = 14;
  localparam int MEM_DATA_W = 64;
  localparam int MEM_TAG_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  function automatic int req_w(int aw, int dw, int tw);
    return 1 + aw + dw + tw;
  endfunction

  localparam int REQ_W = 1 + MEM_ADDR_W + MEM_DATA_W + MEM_TAG_W;

endpackage

// File: rtl/mem_req_queue_if.sv
// Requester-side bundle: request handshake and response pulse.
// master = pipeline, slave = queue.
interface mem_req_queue_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int TAG_W  = MEM_TAG_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  req_tag;
  logic              resp_valid;
  logic              resp_we;
  logic [TAG_W-1:0]  resp_tag;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_tag,
    input  req_ready,
    input  resp_valid, resp_we,
    input  resp_tag, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_tag,
    output req_ready,
    output resp_valid, resp_we,
    output resp_tag, resp_rdata
  );
endinterface

// File: rtl/mem_req_queue_fifo.sv
// Generic DEPTH x W synchronous FIFO.
// Pointers carry an extra MSB to tell full from empty.
module mem_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full)
        wp <= wp + 1'b1;
      if (pop && !empty)
        rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mem_req_queue.sv
// Queues load/store requests and issues them one at a time to memory_interface.
// Define MEMQ_PERF_EN to add the perf_issued / perf_busy counters.
module mem_req_queue
  import mem_pkg::*;
#(
  parameter int DEPTH  = MEM_DEPTH,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int TAG_W  = MEM_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  mem_req_queue_if.slave    q,
  output logic              enable,
  output logic              rd_wrt_mem,
  output logic [ADDR_W-1:0] addr_mem,
  output logic [DATA_W-1:0] data_mem_in,
  input  logic [DATA_W-1:0] data_mem_out,
  input  logic              done
`ifdef MEMQ_PERF_EN
  ,
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_busy
`endif
);
  localparam int EW = req_w(ADDR_W, DATA_W, TAG_W);

  state_t            state;
  logic [EW-1:0]     din;
  logic [EW-1:0]     head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [TAG_W-1:0]  tag_q;
  logic              resp_valid;
  logic              resp_we;
  logic [TAG_W-1:0]  resp_tag;
  logic [DATA_W-1:0] resp_rdata;

  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic [TAG_W-1:0]  h_tag;

  assign din = {q.req_we, q.req_addr,
                q.req_wdata, q.req_tag};
  assign q.req_ready = ~rst & ~full;
  assign push = q.req_valid & q.req_ready;
  assign pop  = (state == IDLE) & ~empty;

  assign {h_we, h_addr, h_wdata, h_tag} = head;

  assign q.resp_valid = resp_valid;
  assign q.resp_we    = resp_we;
  assign q.resp_tag   = resp_tag;
  assign q.resp_rdata = resp_rdata;

  mem_req_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      enable      <= 1'b0;
      rd_wrt_mem  <= 1'b0;
      addr_mem    <= '0;
      data_mem_in <= '0;
      tag_q       <= '0;
      resp_valid  <= 1'b0;
      resp_we     <= 1'b0;
      resp_tag    <= '0;
      resp_rdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (!empty) begin
            enable      <= 1'b1;
            rd_wrt_mem  <= h_we;
            addr_mem    <= h_addr;
            data_mem_in <= h_wdata;
            tag_q       <= h_tag;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            enable     <= 1'b0;
            rd_wrt_mem <= 1'b0;
            resp_valid <= 1'b1;
            resp_we    <= rd_wrt_mem;
            resp_tag   <= tag_q;
            resp_rdata <= rd_wrt_mem ? '0
                                     : data_mem_out;
            state      <= RESP;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEMQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued <= '0;
      perf_busy   <= '0;
    end else begin
      if (pop && perf_issued != '1)
        perf_issued <= perf_issued + 1'b1;
      if (state == BUSY && perf_busy != '1)
        perf_busy <= perf_busy + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_queue.sv
// Bench for mem_req_queue: memory_interface model plus scoreboard.
// Build with MEMQ_PERF_EN to also exercise the perf counters.
module tb_mem_req_queue;
  import mem_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic        we;
    logic [13:0] addr;
    logic [63:0] wdata;
    logic [3:0]  tag;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        rd_wrt_mem;
  logic [13:0] addr_mem;
  logic [63:0] data_mem_in;
  logic [63:0] data_mem_out;
  logic        done;
`ifdef MEMQ_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_busy;
`endif

  always #5 clk = ~clk;

  mem_req_queue_if bus ();

  mem_req_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .q            (bus),
    .enable       (enable),
    .rd_wrt_mem   (rd_wrt_mem),
    .addr_mem     (addr_mem),
    .data_mem_in  (data_mem_in),
    .data_mem_out (data_mem_out),
    .done         (done)
`ifdef MEMQ_PERF_EN
    ,
    .perf_issued  (perf_issued),
    .perf_busy    (perf_busy)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_resp = 0;
  int resp_seen = 0;
  int inject_req = 0;

  ent_t        iss_q[$];
  ent_t        rsp_q[$];
  logic [63:0] shadow [logic [13:0]];
  logic [63:0] mem    [logic [13:0]];
  logic [3:0]  log_tag   [64];
  logic        log_we    [64];
  logic [63:0] log_rdata [64];

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not expected", name);
  endtask

  // memory_interface model: done 5 cycles after enable (write), 6 (read)
  initial begin
    int   cnt;
    int   ack;
    logic act;
    logic m_we;
    logic [13:0] m_addr;
    logic [63:0] m_wdata;
    done = 1'b0;
    data_mem_out = '0;
    cnt = 0;
    ack = 0;
    act = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        done = 1'b0;
        act  = 1'b0;
      end else if (done) begin
        done = 1'b0;
        data_mem_out = {$urandom, $urandom};
      end else if (ack != inject_req) begin
        ack  = inject_req;
        done = 1'b1;
      end else if (act) begin
        cnt--;
        if (cnt == 0) begin
          done = 1'b1;
          act  = 1'b0;
          if (m_we) begin
            mem[m_addr] = m_wdata;
            data_mem_out = {$urandom, $urandom};
          end else begin
            data_mem_out = mem.exists(m_addr) ?
                           mem[m_addr] : 64'd0;
          end
        end
      end else if (enable) begin
        act     = 1'b1;
        m_we    = rd_wrt_mem;
        m_addr  = addr_mem;
        m_wdata = data_mem_in;
        cnt     = rd_wrt_mem ? 4 : 5;
      end
    end
  end

  // scoreboard / per-cycle compare
  initial begin
    logic en_prev;
    logic rv_prev;
    logic push_pend;
    int   occ;
    int   low_cnt;
    logic        l_we;
    logic [13:0] l_addr;
    logic [63:0] l_data;
    logic [63:0] exp_rd;
    ent_t e;
    en_prev = 1'b0;
    rv_prev = 1'b0;
    push_pend = 1'b0;
    occ = 0;
    low_cnt = 99;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        iss_q.delete();
        rsp_q.delete();
        occ = 0;
        push_pend = 1'b0;
        en_prev = 1'b0;
        rv_prev = 1'b0;
        low_cnt = 99;
        chk("rst_enable", enable, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
      end else begin
        if (push_pend) occ++;
        if (enable && en_prev) begin
          chk("hold_we", rd_wrt_mem, l_we);
          chk("hold_addr", addr_mem, l_addr);
          chk("hold_data", data_mem_in, l_data);
        end
        if (enable && !en_prev) begin
          occ--;
          chk("enable_gap", low_cnt >= 2, 1);
          if (iss_q.size() == 0) begin
            fail("issue_unexpected");
          end else begin
            e = iss_q.pop_front();
            chk("issue_we", rd_wrt_mem, e.we);
            chk("issue_addr", addr_mem, e.addr);
            chk("issue_data", data_mem_in, e.wdata);
            rsp_q.push_back(e);
          end
          l_we   = rd_wrt_mem;
          l_addr = addr_mem;
          l_data = data_mem_in;
        end
        if (enable) low_cnt = 0;
        else        low_cnt++;
        if (!enable && en_prev)
          chk("resp_on_done", bus.resp_valid, 1);
        chk("req_ready", bus.req_ready, occ < DEPTH);
        if (bus.resp_valid) begin
          resp_seen++;
          chk("resp_pulse", rv_prev, 0);
          if (rsp_q.size() == 0) begin
            fail("resp_unexpected");
          end else begin
            e = rsp_q.pop_front();
            if (e.we) begin
              exp_rd = 64'd0;
              shadow[e.addr] = e.wdata;
            end else begin
              exp_rd = shadow.exists(e.addr) ?
                       shadow[e.addr] : 64'd0;
            end
            chk("resp_tag", bus.resp_tag, e.tag);
            chk("resp_we", bus.resp_we, e.we);
            chk("resp_rdata", bus.resp_rdata, exp_rd);
            if (n_resp < 64) begin
              log_tag[n_resp]   = bus.resp_tag;
              log_we[n_resp]    = bus.resp_we;
              log_rdata[n_resp] = bus.resp_rdata;
            end
            n_resp++;
          end
        end
        push_pend = bus.req_valid && bus.req_ready;
        if (push_pend) begin
          e.we    = bus.req_we;
          e.addr  = bus.req_addr;
          e.wdata = bus.req_wdata;
          e.tag   = bus.req_tag;
          iss_q.push_back(e);
        end
        en_prev = enable;
        rv_prev = bus.resp_valid;
      end
    end
  end

  task automatic push(input logic        we,
                      input logic [13:0] a,
                      input logic [63:0] d,
                      input logic [3:0]  t);
    int k;
    k = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_tag   = t;
    #1;
    while (!bus.req_ready && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (k >= 100) fail("push_timeout");
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      #2;
      k++;
    end while ((iss_q.size() != 0 || rsp_q.size() != 0 ||
                enable) && k < 500);
    if (k >= 500) fail("drain_timeout");
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int k;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_tag   = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_addr_mem", addr_mem, 0);
    chk("reset_data_mem_in", data_mem_in, 0);
    chk("reset_rd_wrt_mem", rd_wrt_mem, 0);
    chk("reset_resp_tag", bus.resp_tag, 0);
    chk("reset_resp_rdata", bus.resp_rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", bus.req_ready, 1);

    // single write, latency E0 -> E1
    push(1'b1, 14'h0010, 64'hDEADBEEF_00000001, 4'd3);
    chk("latency_e0", enable, 0);
    @(negedge clk);
    chk("latency_e1", enable, 1);
    chk("t1_rd_wrt_mem", rd_wrt_mem, 1);
    chk("t1_addr_mem", addr_mem, 14'h0010);
    drain();
    chk("t1_count", n_resp, 1);
    chk("t1_tag", log_tag[0], 4'd3);
    chk("t1_we", log_we[0], 1);
    chk("t1_rdata", log_rdata[0], 64'd0);

    // read back
    push(1'b0, 14'h0010, 64'd0, 4'd5);
    drain();
    chk("t2_count", n_resp, 2);
    chk("t2_tag", log_tag[1], 4'd5);
    chk("t2_rdata", log_rdata[1], 64'hDEADBEEF_00000001);

    // stray done in IDLE
    inject_req++;
    repeat (6) @(negedge clk);
    chk("idle_done_ignored", resp_seen, 2);

    // five back-to-back, FIFO fills behind the first
    push(1'b1, 14'h0020, 64'h1111_2222_3333_4444, 4'd0);
    push(1'b0, 14'h0020, 64'd0, 4'd1);
    push(1'b1, 14'h0021, 64'hA5A5_0000_FFFF_5A5A, 4'd2);
    push(1'b0, 14'h0021, 64'd0, 4'd3);
    push(1'b1, 14'h0022, 64'h0123_4567_89AB_CDEF, 4'd4);
    chk("t3_full_ready", bus.req_ready, 0);
    drain();
    chk("t3_count", n_resp, 7);
    for (int i = 0; i < 5; i++)
      chk("t3_order", log_tag[2+i], i);
    chk("t3_rd1", log_rdata[3], 64'h1111_2222_3333_4444);
    chk("t3_rd3", log_rdata[5], 64'hA5A5_0000_FFFF_5A5A);
    chk("t3_wr4", log_rdata[6], 64'd0);

    // reset during BUSY of the 2nd of 3
    push(1'b1, 14'h0040, 64'hCAFE_0000_0000_0008, 4'd8);
    push(1'b0, 14'h0040, 64'd0, 4'd9);
    push(1'b1, 14'h0041, 64'hCAFE_0000_0000_000A, 4'd10);
    k = 0;
    do begin
      @(negedge clk);
      #2;
      k++;
    end while (!(n_resp == 8 && enable) && k < 200);
    if (k >= 200) fail("t5_wait_timeout");
    chk("t5_first_tag", log_tag[7], 4'd8);
    rst = 1'b1;
    #1;
    chk("t5_async_enable", enable, 0);
    chk("t5_async_ready", bus.req_ready, 0);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    base = resp_seen;
    repeat (30) @(negedge clk);
    chk("t5_no_resp", resp_seen, base);
    chk("t5_ready_release", bus.req_ready, 1);
    chk("t5_enable_idle", enable, 0);

`ifdef MEMQ_PERF_EN
    chk("perf_issued_reset", perf_issued, 0);
    chk("perf_busy_reset", perf_busy, 0);
    push(1'b1, 14'h0030, 64'h0000_0000_0000_0D0D, 4'd11);
    push(1'b0, 14'h0030, 64'd0, 4'd12);
    push(1'b1, 14'h0031, 64'h0000_0000_0000_0E0E, 4'd13);
    drain();
    chk("perf_issued", perf_issued, 3);
    chk("perf_busy", perf_busy, 16);
    chk("perf_rd", log_rdata[9], 64'h0000_0000_0000_0D0D);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
